rst_seq: RTL and testbench

- Parametrised synthesizable reset sequencer for the demo SoC. It replaces the fixed testbench-style reset pulse.
- Holds N reset domains in reset until the PLL reports lock, then releases them one by one with a programmable stagger.
- Supports per-domain software reset requests and re-entry on loss of lock.
- Sits between the clock wizard/PLL and demo_top's internal domains (core, vector unit, peripherals, UART).
- Drives a heartbeat LED to give board-level liveness indication.

---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/rst_stretch.sv | 44 ++++
 rtl/rst_seq.sv | 181 ++++++++++++++++++
 tb/tb_rst_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the width rule used to size every saturating counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rst_stretch.sv
// Single-domain software reset stretcher: a request loads the counter, and the
// domain stays in reset until the counter has run down to zero.
module rst_stretch #(
  parameter int SW_RST_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_req,
  output logic o_act_nxt
);
  import rst_seq_pkg::*;

  localparam int            CW   = cnt_w(SW_RST_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(SW_RST_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // A held request keeps reloading, so the countdown only starts once it drops.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en && i_req) begin
      w_cnt_nxt = LOAD;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next-cycle activity, so the parent can register it straight into rst_o.
  assign o_act_nxt = (w_cnt_nxt != '0);

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains in reset until PLL lock, releases them in
// index order with a fixed stagger, then services per-domain software resets.
module rst_seq #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int SW_RST_CYCLES  = 8,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int LED_DIV        = 12500000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pll_locked_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   rst_done_o,
  output logic                   lock_timeout_o,
  output logic                   led_o
);
  import rst_seq_pkg::*;

  localparam int HW  = cnt_w(HOLD_CYCLES);
  localparam int SGW = cnt_w(STAGGER_CYCLES);
  localparam int TW  = cnt_w(LOCK_TIMEOUT);
  localparam int LW  = cnt_w(LED_DIV);
  localparam int IW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SGW-1:0] STG_LAST  = SGW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0]  TO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [LW-1:0]  LED_LAST  = LW'(LED_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_DOMAINS - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [HW-1:0]          r_hold_cnt;
  logic [HW-1:0]          w_hold_nxt;
  logic [SGW-1:0]         r_stg_cnt;
  logic [SGW-1:0]         w_stg_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;
  logic [TW-1:0]          r_to_cnt;
  logic [TW-1:0]          w_to_nxt;
  logic                   r_to_flag;
  logic                   w_to_flag_nxt;
  logic [LW-1:0]          r_led_cnt;
  logic [LW-1:0]          w_led_cnt_nxt;
  logic                   r_led;
  logic                   w_led_nxt;
  logic [NUM_DOMAINS-1:0] r_rst;
  logic [NUM_DOMAINS-1:0] w_rst_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic [NUM_DOMAINS-1:0] w_sw_act;
  logic                   w_sw_en;
  logic                   w_sw_clr;

  // Next state and sequencing counters; counters not advanced here restart at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = '0;
    w_stg_nxt   = '0;
    w_idx_nxt   = '0;
    w_to_nxt    = '0;
    unique case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (pll_locked_i) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_to_nxt = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + TW'(1);
        end
      end
      ST_RELEASE: begin
        if (!pll_locked_i) begin
          w_state_nxt = ST_HOLD;
        end else if (r_idx == IDX_LAST) begin
          w_state_nxt = ST_RUN;
        end else if (r_stg_cnt == STG_LAST) begin
          w_idx_nxt = r_idx + IW'(1);
        end else begin
          w_idx_nxt = r_idx;
          w_stg_nxt = r_stg_cnt + SGW'(1);
        end
      end
      ST_RUN: begin
        if (!pll_locked_i) begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  assign w_to_flag_nxt = r_to_flag |
                         ((r_state == ST_WAIT_LOCK) && !pll_locked_i && (w_to_nxt == TO_MAX));

  // Software resets are only accepted in RUN and are flushed whenever RUN is left.
  assign w_sw_en  = (r_state == ST_RUN);
  assign w_sw_clr = (w_state_nxt != ST_RUN);

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    rst_stretch #(
      .SW_RST_CYCLES(SW_RST_CYCLES)
    ) u_stretch (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_en     (w_sw_en),
      .i_clr    (w_sw_clr),
      .i_req    (sw_rst_req_i[g]),
      .o_act_nxt(w_sw_act[g])
    );
  end

  // Reset vector follows the next state: domains above idx stay held in RELEASE.
  always_comb begin
    w_rst_nxt = '1;
    case (w_state_nxt)
      ST_RELEASE: begin
        for (int k = 0; k < NUM_DOMAINS; k++) begin
          w_rst_nxt[k] = (k > int'(w_idx_nxt));
        end
      end
      ST_RUN:  w_rst_nxt = w_sw_act;
      default: w_rst_nxt = '1;
    endcase
    w_done_nxt = (w_state_nxt == ST_RUN) && (w_rst_nxt == '0);
  end

  // Heartbeat runs only while staying in RUN; any exit clears it.
  always_comb begin
    w_led_cnt_nxt = '0;
    w_led_nxt     = 1'b0;
    if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
      if (r_led_cnt == LED_LAST) begin
        w_led_nxt = ~r_led;
      end else begin
        w_led_cnt_nxt = r_led_cnt + LW'(1);
        w_led_nxt     = r_led;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
      r_idx      <= '0;
      r_to_cnt   <= '0;
      r_to_flag  <= 1'b0;
      r_led_cnt  <= '0;
      r_led      <= 1'b0;
      r_rst      <= '1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_stg_cnt  <= w_stg_nxt;
      r_idx      <= w_idx_nxt;
      r_to_cnt   <= w_to_nxt;
      r_to_flag  <= w_to_flag_nxt;
      r_led_cnt  <= w_led_cnt_nxt;
      r_led      <= w_led_nxt;
      r_rst      <= w_rst_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign rst_o          = r_rst;
  assign rst_done_o     = r_done;
  assign lock_timeout_o = r_to_flag;
  assign led_o          = r_led;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: each scenario queues cycle-stamped expected
// outputs as it drives stimulus, then pops and compares them as cycles elapse.
module tb_rst_seq;

  localparam int N = 4;

  logic         clk_i        = 1'b0;
  logic         rst_i        = 1'b1;
  logic         pll_locked_i = 1'b1;
  logic [N-1:0] sw_rst_req_i = '0;
  logic [N-1:0] rst_o;
  logic         rst_done_o;
  logic         lock_timeout_o;
  logic         led_o;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int t_r   = 0;
  int t_run = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       done;
    logic       mled;
    logic       led;
    logic       mto;
    logic       to;
    string      tag;
  } exp_t;

  exp_t q[$];

  rst_seq #(
    .NUM_DOMAINS   (N),
    .HOLD_CYCLES   (16),
    .STAGGER_CYCLES(8),
    .SW_RST_CYCLES (8),
    .LOCK_TIMEOUT  (100),
    .LED_DIV       (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pll_locked_i  (pll_locked_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .rst_o         (rst_o),
    .rst_done_o    (rst_done_o),
    .lock_timeout_o(lock_timeout_o),
    .led_o         (led_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time expired, want scenario completion");
    $fatal(1);
  end

  // Queue an expectation for the outputs seen after posedge number c (kept sorted).
  function automatic void exp_at(input int c, input logic [3:0] r, input logic d, input string tag,
                                 input logic ml = 1'b0, input logic l = 1'b0,
                                 input logic mt = 1'b0, input logic t = 1'b0);
    exp_t e;
    int   i;
    e.cyc = c; e.rst = r; e.done = d; e.mled = ml; e.led = l; e.mto = mt; e.to = t; e.tag = tag;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endfunction

  task automatic test_reset();
    exp_t e;
    int   s = cyc;
    exp_at(s + 1, 4'hF, 1'b0, "reset_state", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_at(s + 5, 4'hF, 1'b0, "reset_state", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 100; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s + 5) begin rst_i = 1'b0; t_r = cyc; end
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL reset budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_release();
    exp_t e;
    int   r = t_r;
    exp_at(r + 1,  4'hF, 1'b0, "rel_hold");
    exp_at(r + 16, 4'hF, 1'b0, "rel_waitlock");
    exp_at(r + 17, 4'hE, 1'b0, "rel_d0");
    exp_at(r + 24, 4'hE, 1'b0, "rel_d0_hold");
    exp_at(r + 25, 4'hC, 1'b0, "rel_d1");
    exp_at(r + 32, 4'hC, 1'b0, "rel_d1_hold");
    exp_at(r + 33, 4'h8, 1'b0, "rel_d2");
    exp_at(r + 40, 4'h8, 1'b0, "rel_d2_hold");
    exp_at(r + 41, 4'h0, 1'b0, "rel_d3");
    exp_at(r + 42, 4'h0, 1'b1, "rel_done");
    for (int g = 0; g < 200; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL release budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
    t_run = r + 42;
  endtask

  task automatic test_heartbeat();
    exp_t e;
    int   s = cyc;
    int   d = s + 13;
    for (int c = s + 1; c <= s + 12; c++)
      exp_at(c, 4'h0, 1'b1, "hb_led", 1'b1, 1'(((c - t_run) / 4) % 2));
    exp_at(d,      4'hF, 1'b0, "hb_lock_loss", 1'b1, 1'b0);
    exp_at(d + 16, 4'hF, 1'b0, "hb_rel_hold", 1'b1, 1'b0);
    exp_at(d + 17, 4'hE, 1'b0, "hb_rel_d0");
    exp_at(d + 25, 4'hC, 1'b0, "hb_rel_d1");
    exp_at(d + 33, 4'h8, 1'b0, "hb_rel_d2");
    exp_at(d + 41, 4'h0, 1'b0, "hb_rel_d3");
    exp_at(d + 42, 4'h0, 1'b1, "hb_run2", 1'b1, 1'b0);
    exp_at(d + 46, 4'h0, 1'b1, "hb_run2_led", 1'b1, 1'b1);
    for (int g = 0; g < 300; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s + 12) pll_locked_i = 1'b0;
      if (cyc == s + 13) pll_locked_i = 1'b1;
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL heartbeat budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
    t_run = d + 42;
  endtask

  task automatic test_timeout();
    exp_t e;
    int   s = cyc;
    int   r = s + 3;
    exp_at(s + 1,   4'hF, 1'b0, "to_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_at(r + 16,  4'hF, 1'b0, "to_waitlock", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_at(r + 115, 4'hF, 1'b0, "to_before", 1'b0, 1'b0, 1'b1, 1'b0);
    exp_at(r + 116, 4'hF, 1'b0, "to_flag", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_at(r + 150, 4'hF, 1'b0, "to_sticky", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_at(r + 151, 4'hE, 1'b0, "to_rel_d0", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_at(r + 159, 4'hC, 1'b0, "to_rel_d1");
    exp_at(r + 167, 4'h8, 1'b0, "to_rel_d2");
    exp_at(r + 175, 4'h0, 1'b0, "to_rel_d3");
    exp_at(r + 176, 4'h0, 1'b1, "to_done", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int g = 0; g < 400; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s) begin rst_i = 1'b1; pll_locked_i = 1'b0; end
      if (cyc == r) rst_i = 1'b0;
      if (cyc == r + 150) pll_locked_i = 1'b1;
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
    t_run = r + 176;
  endtask

  task automatic test_sw_reset();
    exp_t e;
    int   s = cyc;
    exp_at(s,      4'h0, 1'b1, "sw_idle");
    exp_at(s + 1,  4'h4, 1'b0, "sw_pulse_on");
    exp_at(s + 5,  4'h4, 1'b0, "sw_pulse_mid");
    exp_at(s + 8,  4'h4, 1'b0, "sw_pulse_last");
    exp_at(s + 9,  4'h0, 1'b1, "sw_pulse_off");
    exp_at(s + 13, 4'h9, 1'b0, "sw_multi_on");
    exp_at(s + 20, 4'h9, 1'b0, "sw_multi_last");
    exp_at(s + 21, 4'h0, 1'b1, "sw_multi_off");
    exp_at(s + 25, 4'h2, 1'b0, "sw_held_on");
    exp_at(s + 34, 4'h2, 1'b0, "sw_held_last");
    exp_at(s + 35, 4'h0, 1'b1, "sw_held_off");
    for (int g = 0; g < 200; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s)      sw_rst_req_i = 4'b0100;
      if (cyc == s + 1)  sw_rst_req_i = 4'b0000;
      if (cyc == s + 12) sw_rst_req_i = 4'b1001;
      if (cyc == s + 13) sw_rst_req_i = 4'b0000;
      if (cyc == s + 24) sw_rst_req_i = 4'b0010;
      if (cyc == s + 27) sw_rst_req_i = 4'b0000;
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sw_reset budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int   s = cyc;
    int   d = s + 4;
    exp_at(s + 1,  4'h2, 1'b0, "ll_sw_on");
    exp_at(s + 3,  4'h2, 1'b0, "ll_sw_mid");
    exp_at(d,      4'hF, 1'b0, "ll_hold", 1'b1, 1'b0);
    exp_at(d + 16, 4'hF, 1'b0, "ll_waitlock");
    exp_at(d + 17, 4'hE, 1'b0, "ll_rel_d0");
    exp_at(d + 21, 4'hE, 1'b0, "ll_req_ignored");
    exp_at(d + 22, 4'hE, 1'b0, "ll_req_ignored");
    exp_at(d + 25, 4'hC, 1'b0, "ll_rel_d1");
    exp_at(d + 33, 4'h8, 1'b0, "ll_rel_d2");
    exp_at(d + 41, 4'h0, 1'b0, "ll_rel_d3");
    exp_at(d + 42, 4'h0, 1'b1, "ll_done");
    exp_at(d + 44, 4'h0, 1'b1, "ll_run_clean");
    for (int g = 0; g < 200; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s)      sw_rst_req_i = 4'b0010;
      if (cyc == s + 1)  sw_rst_req_i = 4'b0000;
      if (cyc == s + 3)  pll_locked_i = 1'b0;
      if (cyc == d)      pll_locked_i = 1'b1;
      if (cyc == d + 20) sw_rst_req_i = 4'b0001;
      if (cyc == d + 21) sw_rst_req_i = 4'b0000;
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL lock_loss budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    int   s  = cyc;
    int   r  = s + 3;
    int   r2 = r + 30;
    exp_at(s + 1,   4'hF, 1'b0, "mid_reset", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_at(r + 17,  4'hE, 1'b0, "mid_rel_d0");
    exp_at(r + 25,  4'hC, 1'b0, "mid_rel_d1");
    exp_at(r + 28,  4'hC, 1'b0, "mid_before");
    exp_at(r + 29,  4'hF, 1'b0, "mid_abort", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_at(r2 + 1,  4'hF, 1'b0, "mid_hold");
    exp_at(r2 + 17, 4'hE, 1'b0, "mid_re_d0");
    exp_at(r2 + 25, 4'hC, 1'b0, "mid_re_d1");
    exp_at(r2 + 33, 4'h8, 1'b0, "mid_re_d2");
    exp_at(r2 + 41, 4'h0, 1'b0, "mid_re_d3");
    exp_at(r2 + 42, 4'h0, 1'b1, "mid_done", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 300; g++) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (rst_o !== e.rst || rst_done_o !== e.done || (e.mled && led_o !== e.led) || (e.mto && lock_timeout_o !== e.to)) begin
          n_err++;
          $display("FAIL %s cyc %0d: got rst_o=%h done=%b led=%b to=%b, want rst_o=%h done=%b led=%b to=%b",
                   e.tag, cyc, rst_o, rst_done_o, led_o, lock_timeout_o, e.rst, e.done, e.led, e.to);
        end
      end
      if (cyc == s)      rst_i = 1'b1;
      if (cyc == r)      rst_i = 1'b0;
      if (cyc == r + 28) rst_i = 1'b1;
      if (cyc == r2)     rst_i = 1'b0;
      if (q.size() == 0) break;
      @(negedge clk_i);
    end
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rst_mid budget: %0d expectations pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_release();
    test_heartbeat();
    test_timeout();
    test_sw_reset();
    test_lock_loss();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
